// File: rtl/md_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package md_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4,
      ST_EXC   = 3'd5
   } state_t;

   // Latched operation
   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   // Operand source; also the DivSrc and HiCtrl/LoCtrl mux encodings
   localparam logic SRC_REG = 1'b0;
   localparam logic SRC_MEM = 1'b1;

endpackage

// File: rtl/md_iter_counter.sv
// Loadable down-counter that paces the iterative mult/div datapath.
module md_iter_counter #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] count_q;

   // Count register: load wins over decrement; saturates at zero
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (load) begin
         // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
         count_q <= load_val;
      end else if (en && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/multdiv_seq_ctrl.sv
// Multicycle sequencer for the HI/LO multiply/divide path: latches the
// request, selects operand sources, steps the datapath, writes HI/LO.
module multdiv_seq_ctrl
   import md_ctrl_pkg::*;
#(
   parameter int ITERATIONS = 32,
   parameter int CNT_W      = 6
) (
   input  logic clk,
   input  logic reset,
   input  logic mult_start,
   input  logic div_start,
   input  logic divm,
   input  logic abort,
   input  logic divisor_zero,
   output logic div_src_a_sel,
   output logic div_src_b_sel,
   output logic md_load,
   output logic md_step,
   output logic hi_ctrl,
   output logic lo_ctrl,
   output logic hi_wr,
   output logic lo_wr,
   output logic busy,
   output logic done,
   output logic div_zero_exc
);

   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(ITERATIONS - 1);

   state_t state_q, state_d;
   logic   op_q;
   logic   divm_q;
   logic   cnt_load;
   logic   cnt_en;
   logic   cnt_zero;

   md_iter_counter #(.CNT_W(CNT_W)) u_iter_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .en       (cnt_en),
      .load_val (LOAD_VAL),
      .zero     (cnt_zero)
   );

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Request latch: only sampled in IDLE, MULT has priority over DIV
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q   <= OP_MULT;
         divm_q <= SRC_REG;
      end else if (state_q == ST_IDLE) begin
         if (mult_start) begin
            op_q   <= OP_MULT;
            divm_q <= SRC_REG;
         end else if (div_start) begin
            op_q   <= OP_DIV;
            divm_q <= divm;
         end
      end
   end

   // Next-state and counter control; abort returns to IDLE from any busy state
   always_comb begin
      // NOTE: defaults first so every path assigns every signal and no latch is inferred.
      state_d  = state_q;
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (mult_start || div_start) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            cnt_load = 1'b1;
            if (abort)                                  state_d = ST_IDLE;
            else if ((op_q == OP_DIV) && divisor_zero)  state_d = ST_EXC;
            else                                        state_d = ST_RUN;
         end
         ST_RUN: begin
            if (abort)         state_d = ST_IDLE;
            else if (cnt_zero) state_d = ST_WRITE;
            else               cnt_en  = 1'b1;
         end
         ST_WRITE: begin
            state_d = abort ? ST_IDLE : ST_DONE;
         end
         ST_DONE, ST_EXC: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Moore output decode from registered state and latched request
   always_comb begin
      div_src_a_sel = SRC_REG;
      div_src_b_sel = SRC_REG;
      md_load       = 1'b0;
      md_step       = 1'b0;
      hi_ctrl       = SRC_REG;
      lo_ctrl       = SRC_REG;
      hi_wr         = 1'b0;
      lo_wr         = 1'b0;
      busy          = (state_q != ST_IDLE);
      done          = 1'b0;
      div_zero_exc  = 1'b0;
      unique case (state_q)
         ST_LOAD: begin
            md_load       = 1'b1;
            div_src_a_sel = divm_q;
            div_src_b_sel = divm_q;
         end
         ST_RUN: begin
            md_step       = 1'b1;
            div_src_a_sel = divm_q;
            div_src_b_sel = divm_q;
         end
         ST_WRITE: begin
            hi_wr   = 1'b1;
            lo_wr   = 1'b1;
            hi_ctrl = (op_q == OP_DIV) ? SRC_MEM : SRC_REG;
            lo_ctrl = (op_q == OP_DIV) ? SRC_MEM : SRC_REG;
         end
         ST_DONE: done         = 1'b1;
         ST_EXC:  div_zero_exc = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multdiv_seq_ctrl.sv
// Scoreboard bench for multdiv_seq_ctrl: a timeline model predicts the
// output vector for every cycle, a monitor compares after each edge.
module tb_multdiv_seq_ctrl;

   localparam int ITER = 32;

   logic clk = 1'b1;
   logic reset = 1'b0;
   logic mult_start = 1'b0, div_start = 1'b0, divm = 1'b0;
   logic abort = 1'b0, divisor_zero = 1'b0;
   logic div_src_a_sel, div_src_b_sel, md_load, md_step;
   logic hi_ctrl, lo_ctrl, hi_wr, lo_wr, busy, done, div_zero_exc;

   always #5 clk = ~clk;

   multdiv_seq_ctrl #(.ITERATIONS(ITER), .CNT_W(6)) dut (
      .clk           (clk),
      .reset         (reset),
      .mult_start    (mult_start),
      .div_start     (div_start),
      .divm          (divm),
      .abort         (abort),
      .divisor_zero  (divisor_zero),
      .div_src_a_sel (div_src_a_sel),
      .div_src_b_sel (div_src_b_sel),
      .md_load       (md_load),
      .md_step       (md_step),
      .hi_ctrl       (hi_ctrl),
      .lo_ctrl       (lo_ctrl),
      .hi_wr         (hi_wr),
      .lo_wr         (lo_wr),
      .busy          (busy),
      .done          (done),
      .div_zero_exc  (div_zero_exc)
   );

   // {sel_a, sel_b, load, step, hi_ctrl, lo_ctrl, hi_wr, lo_wr, busy, done, exc}
   logic [10:0] dut_vec;
   assign dut_vec = {div_src_a_sel, div_src_b_sel, md_load, md_step, hi_ctrl,
                     lo_ctrl, hi_wr, lo_wr, busy, done, div_zero_exc};

   logic [10:0] exp_q[$];
   int  tests = 0, fails = 0;
   int  exp_done = 0, obs_done = 0;
   bit  started = 1'b0;

   // Reference model: cycles elapsed since an accepted start
   bit  m_busy = 0, m_exc = 0, m_div = 0, m_mem = 0;
   int  m_t = 0;

   function automatic logic [10:0] model_out();
      bit ld, st, wr, dn, ex, sel;
      ld  = m_busy && (m_t == 1);
      st  = m_busy && !m_exc && (m_t >= 2) && (m_t <= ITER + 1);
      wr  = m_busy && (m_t == ITER + 2);
      dn  = m_busy && (m_t == ITER + 3);
      ex  = m_busy && m_exc && (m_t == 2);
      sel = m_mem && (ld || st);
      return {sel, sel, ld, st, wr && m_div, wr && m_div, wr, wr, m_busy, dn, ex};
   endfunction

   task automatic model_step();
      if (!reset) begin
         m_busy = 0; m_exc = 0; m_div = 0; m_mem = 0; m_t = 0;
      end else if (!m_busy) begin
         if (mult_start) begin
            m_busy = 1; m_t = 1; m_div = 0; m_mem = 0; m_exc = 0;
         end else if (div_start) begin
            m_busy = 1; m_t = 1; m_div = 1; m_mem = divm; m_exc = 0;
         end
      end else if (abort) begin
         m_busy = 0;
      end else if ((m_t == 1) && m_div && divisor_zero) begin
         m_exc = 1; m_t = 2;
      end else if ((m_exc && (m_t == 2)) || (m_t == ITER + 3)) begin
         m_busy = 0;
      end else begin
         m_t++;
      end
   endtask

   task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   // One clock of stimulus: drive on the falling edge, predict the post-edge outputs
   task automatic cycle(input bit ms, input bit ds, input bit dm, input bit ab,
                        input bit dz, input bit rs = 1'b1);
      logic [10:0] e;
      @(negedge clk);
      reset        = rs;
      mult_start   = ms;
      div_start    = ds;
      divm         = dm;
      abort        = ab;
      divisor_zero = dz;
      model_step();
      e = model_out();
      if (e[1]) exp_done++;
      exp_q.push_back(e);
      started = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
   endtask

   // Monitor: compare the DUT against the oldest prediction after every edge
   initial begin
      logic [10:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("outputs", dut_vec, e);
            if (done) obs_done++;
         end else if (started) begin
            tests++;
            fails++;
            $display("FAIL scoreboard @%0t: no prediction queued, dut %b", $time, dut_vec);
         end
      end
   end

   initial begin
      // Reset held for a few cycles
      cycle(0, 0, 0, 0, 0, 0);
      cycle(1, 1, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      idle(2);

      // 1. MULT full sequence
      cycle(1, 0, 0, 0, 0);
      idle(ITER + 5);

      // 2. DIVM, nonzero divisor
      cycle(0, 1, 1, 0, 0);
      idle(ITER + 5);

      // 3. DIV with zero divisor
      cycle(0, 1, 0, 0, 1);
      cycle(0, 0, 0, 0, 1);
      idle(4);

      // 4. Simultaneous starts, then a stray div_start at E+10
      cycle(1, 1, 1, 0, 0);
      idle(9);
      cycle(0, 1, 0, 0, 0);
      idle(ITER);

      // 5. Abort at E+15 then immediate restart
      cycle(0, 1, 1, 0, 0);
      idle(14);
      cycle(0, 0, 0, 1, 0);
      cycle(1, 0, 0, 0, 0);
      idle(ITER + 4);

      // abort while idle does nothing
      cycle(0, 0, 0, 1, 0);
      idle(1);

      // 6. Asynchronous reset mid-RUN
      cycle(0, 1, 0, 0, 0);
      idle(10);
      @(posedge clk);
      #3 reset = 1'b0;
      #1 check("async_reset", dut_vec, '0);
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0);
      idle(1);
      cycle(0, 1, 1, 0, 0);
      idle(ITER + 5);

      // Randomised operations with spurious starts, aborts and divisor flags
      for (int n = 0; n < 40; n++) begin
         bit ms, ds;
         idle($urandom_range(0, 3));
         ms = ($urandom_range(0, 1) == 1);
         ds = !ms || ($urandom_range(0, 3) == 0);
         cycle(ms, ds, 1'($urandom_range(0, 1)), 1'b0, ($urandom_range(0, 3) == 0));
         for (int c = 0; c < ITER + 10 && m_busy; c++) begin
            cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 2) == 0));
         end
      end
      idle(3);

      @(posedge clk);
      #2;
      started = 1'b0;
      tests++;
      if (obs_done != exp_done) begin
         fails++;
         $display("FAIL done_count: got %0d expected %0d", obs_done, exp_done);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
